conv_relu_maxpool: RTL and testbench
====================================

Name: conv_relu_maxpool

Overview:
- Downstream consumer of the 3x3 convolution core.
- Once the core signals completion, the block sweeps the core's inference read port and captures the full output map into a local buffer.
- Each captured value passes through ReLU; the block then streams 2x2 stride-1 max-pooled results over a valid/ready interface.
- Sits between the convolution core and the result sink (display/UART packer).

Parameters:
- DATA_W, 12, width of conv results and pooled outputs (signed two's complement).
- IMG_W, 3, conv output map width.
- IMG_H, 3, conv output map height.
- ADDR_W, 4, width of conv read address; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- RD_LAT, 1, cycles from conv_addr change to valid conv_data; legal values 0..3.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- start, input, 1, one-cycle pulse: conv core has finished computing; honoured only in IDLE.
- conv_infer, output, 1, drives the conv core's infer input; high only while fetching.
- conv_addr, output, ADDR_W, read address into conv results, row-major.
- conv_data, input, DATA_W, conv result for the address presented RD_LAT cycles earlier.
- pool_valid, output, 1, pool_data/pool_idx valid.
- pool_ready, input, 1, sink accepts the current word.
- pool_data, output, DATA_W, pooled value (always >= 0).
- pool_idx, output, ADDR_W, row-major index of the pooled output, 0..(IMG_H-1)*(IMG_W-1)-1.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse after the last pooled word is accepted.

Behaviour:
- Reset: all outputs are 0; state IDLE; buffer contents don't-care. Reset asserted mid-operation aborts immediately; no done pulse.
- Let N = IMG_W*IMG_H and P = (IMG_H-1)*(IMG_W-1).
- States: IDLE, FETCH, DRAIN, EMIT.
- IDLE:
  - conv_infer=0, conv_addr=0.
  - When start=1, go to FETCH next cycle.
  - start in any other state is ignored, not queued.
- FETCH:
  - conv_infer=1; conv_addr steps 0,1,...,N-1, one per cycle.
  - Go to DRAIN after addr N-1 if RD_LAT>0; otherwise go straight to EMIT.
- Capture:
  - conv_data is sampled exactly RD_LAT cycles after each address is presented.
  - The sample is written to buf[addr] as max(value,0): sign bit set gives 0, otherwise the value unchanged.
- DRAIN:
  - conv_infer stays 1 and conv_addr holds N-1.
  - Lasts RD_LAT cycles, then go to EMIT.
- EMIT:
  - conv_infer=0, conv_addr=0.
  - Output k, with r=k/(IMG_W-1) and c=k%(IMG_W-1), is the max of buf[r*IMG_W+c], buf[r*IMG_W+c+1], buf[(r+1)*IMG_W+c] and buf[(r+1)*IMG_W+c+1].
  - The comparison is unsigned, since all values are >= 0 after ReLU.
  - pool_data and pool_idx are registered. pool_valid rises on the first EMIT cycle.
  - Handshake:
    - A word transfers on a cycle where pool_valid and pool_ready are both 1; the next word appears on the following cycle.
    - While pool_ready=0, pool_data and pool_idx hold stable and pool_valid stays 1.
    - pool_valid never drops before transfer.
  - After transfer of word P-1: pool_valid=0, done=1 for one cycle, return to IDLE.
  - Back-to-back start is accepted on the cycle after done.
- Latency: with start sampled at edge 0 and pool_ready held at 1, pool_valid is first high N+RD_LAT+1 cycles after that edge (11 with defaults). One pooled word is produced per cycle thereafter.
- Arithmetic: no overflow is possible; widths are preserved throughout. The value -2^(DATA_W-1) clamps to 0.

Test Plan:
- Nominal 3x3 case:
  - Stimulus: conv outputs at addr 0..8 = 1,-5,3,-2,4,6,8,-7,2; start pulse; pool_ready=1.
  - Required response: words (idx,data) = (0,4),(1,6),(2,8),(3,6); done pulses once after idx 3; busy low afterwards.
- Latency and address sequence:
  - Stimulus: defaults with start at edge 0.
  - Required response: conv_addr 0..8 on consecutive cycles with conv_infer=1 through DRAIN; first pool_valid exactly 11 cycles after the start edge.
- Backpressure:
  - Stimulus: same data as the nominal case; pool_ready pattern 0,0,1,0,1,1,0,1.
  - Required response: each word held stable while ready=0; sequence 4,6,8,6 with no loss or duplication; done only after the 4th transfer.
- ReLU and extremes:
  - Stimulus: all outputs 0x800 (-2048) gives all pooled words 0. Then one run with addr4=0x7FF and the rest -1.
  - Required response: first run, all pooled words 0. Second run, all four pooled words 0x7FF.
- Control robustness:
  - Stimulus: start pulsed during FETCH and EMIT.
  - Required response: those pulses are ignored and exactly one done per accepted start. A second start on the cycle after done begins a new FETCH.
- Reset mid-operation:
  - Stimulus: rst driven low during EMIT with pool_ready=0.
  - Required response: all outputs 0 asynchronously, no done pulse. After release, a fresh start reproduces the nominal results.

Source files
------------

// File: rtl/conv_relu_maxpool.sv
// Sweeps the conv core's result port into a ReLU-clamped local map, then streams
// 2x2 stride-1 max-pooled words over a valid/ready interface.
module conv_relu_maxpool #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 3,
  parameter int IMG_H  = 3,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              conv_infer,
  output logic [ADDR_W-1:0] conv_addr,
  input  logic [DATA_W-1:0] conv_data,
  output logic              pool_valid,
  input  logic              pool_ready,
  output logic [DATA_W-1:0] pool_data,
  output logic [ADDR_W-1:0] pool_idx,
  output logic              busy,
  output logic              done
);
  localparam int N = IMG_W * IMG_H;
  localparam int P = (IMG_H - 1) * (IMG_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(P - 1);
  localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, EMIT} state_t;

  state_t            state_q, state_d;
  logic              conv_infer_q, conv_infer_d;
  logic [ADDR_W-1:0] conv_addr_q, conv_addr_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d, k_q, k_d;
  logic              pool_valid_q, pool_valid_d;
  logic [DATA_W-1:0] pool_data_q, pool_data_d;
  logic [ADDR_W-1:0] pool_idx_q, pool_idx_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [DATA_W-1:0] map_q [N];
  logic              fetch, cap_en;
  logic [ADDR_W-1:0] cap_addr;

  assign fetch = (state_q == FETCH);

  // Capture tap lines up with the address that produced the sample RD_LAT cycles ago.
  generate
    if (RD_LAT == 0) begin : g_cap_comb
      assign cap_en   = fetch;
      assign cap_addr = conv_addr_q;
    end else begin : g_cap_pipe
      logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
      logic [ADDR_W-1:0] addr_sr_q [RD_LAT];

      always_comb begin
        vld_sr_d = vld_sr_q;
        for (int i = RD_LAT - 1; i > 0; i--) vld_sr_d[i] = vld_sr_q[i-1];
        vld_sr_d[0] = fetch;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_sr_q <= '0;
        else      vld_sr_q <= vld_sr_d;
      end

      always_ff @(posedge clk) begin
        addr_sr_q[0] <= conv_addr_q;
        for (int i = 1; i < RD_LAT; i++) addr_sr_q[i] <= addr_sr_q[i-1];
      end

      assign cap_en   = vld_sr_q[RD_LAT-1];
      assign cap_addr = addr_sr_q[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (cap_en) map_q[cap_addr] <= conv_data[DATA_W-1] ? '0 : conv_data;
  end

  // After ReLU every entry is non-negative, so an unsigned compare is sufficient.
  logic [ADDR_W-1:0] a00, a01, a10, a11;
  logic [DATA_W-1:0] win_max;
  always_comb begin
    a00 = row_q * ROW_STEP + col_q;
    a01 = a00 + ONE;
    a10 = a00 + ROW_STEP;
    a11 = a10 + ONE;
    win_max = map_q[a00];
    if (map_q[a01] > win_max) win_max = map_q[a01];
    if (map_q[a10] > win_max) win_max = map_q[a10];
    if (map_q[a11] > win_max) win_max = map_q[a11];
  end

  always_comb begin
    state_d      = state_q;
    conv_infer_d = conv_infer_q;
    conv_addr_d  = conv_addr_q;
    drain_cnt_d  = drain_cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    k_d          = k_q;
    pool_valid_d = pool_valid_q;
    pool_data_d  = pool_data_q;
    pool_idx_d   = pool_idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d      = FETCH;
        conv_infer_d = 1'b1;
        conv_addr_d  = '0;
        busy_d       = 1'b1;
        row_d        = '0;
        col_d        = '0;
        k_d          = '0;
      end
      FETCH: begin
        if (conv_addr_q == ADDR_LAST) begin
          if (RD_LAT > 0) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end else begin
            state_d      = EMIT;
            conv_infer_d = 1'b0;
            conv_addr_d  = '0;
          end
        end else begin
          conv_addr_d = conv_addr_q + ONE;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d      = EMIT;
          conv_infer_d = 1'b0;
          conv_addr_d  = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      EMIT: begin
        if (pool_valid_q && pool_ready && pool_idx_q == IDX_LAST) begin
          pool_valid_d = 1'b0;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (!pool_valid_q || pool_ready) begin
          pool_valid_d = 1'b1;
          pool_data_d  = win_max;
          pool_idx_d   = k_q;
          k_d          = k_q + ONE;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ONE;
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      conv_infer_q <= 1'b0;
      conv_addr_q  <= '0;
      drain_cnt_q  <= '0;
      row_q        <= '0;
      col_q        <= '0;
      k_q          <= '0;
      pool_valid_q <= 1'b0;
      pool_data_q  <= '0;
      pool_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_infer_q <= conv_infer_d;
      conv_addr_q  <= conv_addr_d;
      drain_cnt_q  <= drain_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      k_q          <= k_d;
      pool_valid_q <= pool_valid_d;
      pool_data_q  <= pool_data_d;
      pool_idx_q   <= pool_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign conv_infer = conv_infer_q;
  assign conv_addr  = conv_addr_q;
  assign pool_valid = pool_valid_q;
  assign pool_data  = pool_data_q;
  assign pool_idx   = pool_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_conv_relu_maxpool.sv
// Bench for conv_relu_maxpool: a registered-read conv core model feeds the DUT and a
// queue-based pooling model checks every word, handshake and done pulse.
module tb_conv_relu_maxpool;
  localparam int DW = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pool_ready = 1'b0;
  logic [DW-1:0] conv_data = '0;
  logic          conv_infer, pool_valid, busy, done;
  logic [AW-1:0] conv_addr, pool_idx;
  logic [DW-1:0] pool_data;

  logic [DW-1:0] mem [16];
  int  tests = 0, fails = 0, done_cnt = 0, rdy_mode = 0, pi = 0;
  int  exp_idx[$], exp_dat[$];
  bit  pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  bit  prev_pend = 1'b0;

  conv_relu_maxpool dut (
    .clk(clk), .rst(rst), .start(start), .conv_infer(conv_infer), .conv_addr(conv_addr),
    .conv_data(conv_data), .pool_valid(pool_valid), .pool_ready(pool_ready),
    .pool_data(pool_data), .pool_idx(pool_idx), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Conv core: data for the address seen at an edge appears just after that edge.
  initial begin : conv_core
    logic [AW-1:0] a;
    forever begin
      @(posedge clk);
      a = conv_addr;
      #1 conv_data = mem[a];
    end
  end

  // Sink: mode 0 always ready, 1 follows pat[] per valid cycle, 2 never ready.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: pool_ready = 1'b1;
      1: if (pool_valid) begin pool_ready = pat[pi % 8]; pi++; end else pool_ready = 1'b0;
      default: pool_ready = 1'b0;
    endcase
  end

  task automatic set_map(input int v [9]);
    for (int i = 0; i < 16; i++) mem[i] = (i < 9) ? DW'(v[i]) : '0;
  endtask

  // Model: ReLU the 3x3 map, then 2x2 stride-1 max over the four windows.
  task automatic load_expect();
    int v [9];
    int m, b;
    for (int i = 0; i < 9; i++) begin
      v[i] = int'($signed(mem[i]));
      if (v[i] < 0) v[i] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      b = (k / 2) * 3 + (k % 2);
      m = v[b];
      if (v[b+1] > m) m = v[b+1];
      if (v[b+3] > m) m = v[b+3];
      if (v[b+4] > m) m = v[b+4];
      exp_idx.push_back(k);
      exp_dat.push_back(m);
    end
  endtask

  // Compare process: every meaningful cycle, against the model queue.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) chk("valid_held", pool_valid, 1);
      if (pool_valid) begin
        if (exp_idx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got idx %0d data %0d, required no word", pool_idx, pool_data);
        end else begin
          chk("pool_idx", pool_idx, exp_idx[0]);
          chk("pool_data", pool_data, exp_dat[0]);
          if (pool_ready) begin
            $display("[TB] xfer idx=%0d data=%0d", pool_idx, pool_data);
            void'(exp_idx.pop_front());
            void'(exp_dat.pop_front());
          end
        end
      end
      prev_pend = pool_valid && !pool_ready;
      if (done) begin
        done_cnt++;
        $display("[TB] done");
        chk("done_after_last", exp_idx.size(), 0);
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit chain);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    else begin
      chk("busy_at_done", busy, 0);
      chk("valid_at_done", pool_valid, 0);
    end
    if (chain) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (pool_valid) seen = 1'b1;
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_infer"}, conv_infer, 0);
    chk({tag, "_addr"}, conv_addr, 0);
    chk({tag, "_valid"}, pool_valid, 0);
    chk({tag, "_data"}, pool_data, 0);
    chk({tag, "_idx"}, pool_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nominal [9] = '{1, -5, 3, -2, 4, 6, 8, -7, 2};
    int vals [9];
    int d0;

    #12 chk_all_zero("reset");
    @(negedge clk) rst = 1'b1;

    // Nominal run, with latency and address sequence checked cycle by cycle.
    set_map(nominal);
    load_expect();
    chk("model_w0", exp_dat[0], 4);
    chk("model_w1", exp_dat[1], 6);
    chk("model_w2", exp_dat[2], 8);
    chk("model_w3", exp_dat[3], 6);
    rdy_mode = 0;
    d0 = done_cnt;
    do_start();
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j <= 8) begin
        chk("fetch_infer", conv_infer, 1);
        chk("fetch_addr", conv_addr, j);
        chk("fetch_busy", busy, 1);
      end else if (j == 9) begin
        chk("drain_infer", conv_infer, 1);
        chk("drain_addr", conv_addr, 8);
      end else if (j == 10) begin
        chk("emit_infer", conv_infer, 0);
        chk("valid_not_yet", pool_valid, 0);
      end else begin
        chk("first_valid_at_11", pool_valid, 1);
      end
    end
    wait_done(40, 1'b0);
    @(negedge clk);
    chk("nominal_done_cnt", done_cnt - d0, 1);
    chk("nominal_busy_after", busy, 0);

    // Backpressure with ready pattern 0,0,1,0,1,1,0,1.
    load_expect();
    pi = 0;
    rdy_mode = 1;
    d0 = done_cnt;
    do_start();
    wait_done(60, 1'b0);
    @(negedge clk);
    chk("bp_done_cnt", done_cnt - d0, 1);
    chk("bp_all_words", exp_idx.size(), 0);

    // ReLU clamp of the most negative value.
    rdy_mode = 0;
    for (int i = 0; i < 9; i++) vals[i] = -2048;
    set_map(vals);
    load_expect();
    chk("model_neg_w0", exp_dat[0], 0);
    do_start();
    wait_done(40, 1'b0);

    // Single positive maximum in the centre reaches every window.
    for (int i = 0; i < 9; i++) vals[i] = -1;
    vals[4] = 2047;
    set_map(vals);
    load_expect();
    chk("model_max_w3", exp_dat[3], 2047);
    do_start();
    wait_done(40, 1'b0);

    // Stray starts in FETCH and EMIT are ignored; back-to-back start after done.
    set_map(nominal);
    load_expect();
    pi = 0;
    rdy_mode = 1;
    d0 = done_cnt;
    do_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(30);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(60, 1'b1);
    load_expect();
    rdy_mode = 0;
    @(negedge clk);
    chk("b2b_infer", conv_infer, 1);
    chk("b2b_addr", conv_addr, 0);
    wait_done(40, 1'b0);
    repeat (10) @(negedge clk);
    chk("ctrl_done_cnt", done_cnt - d0, 2);
    chk("ctrl_busy_idle", busy, 0);

    // Asynchronous reset during a stalled EMIT.
    set_map(nominal);
    load_expect();
    rdy_mode = 2;
    do_start();
    wait_valid(30);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1 chk_all_zero("midreset");
    exp_idx.delete();
    exp_dat.delete();
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_done", done, 0);
    end
    rst = 1'b1;
    rdy_mode = 0;
    load_expect();
    do_start();
    wait_done(40, 1'b0);
    @(negedge clk);
    chk("post_reset_done_cnt", done_cnt - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
